// File: rtl/npu_tile_sched_if.sv
// Datapath-side bundle of npu_tile_sched: MAC step presentation and output-tile drain handshake.
// The scheduler is the master; the datapath and memories sit on the slave side.
interface npu_tile_sched_if #(
  parameter int unsigned K        = 5,
  parameter int unsigned NB_TILE  = 4,
  parameter int unsigned NB_TILEB = 6,
  parameter int unsigned NB_TILEC = 16
);
  localparam int unsigned KK = K * K;
  localparam int unsigned WA = $clog2(KK * NB_TILEC);
  localparam int unsigned AA = $clog2(NB_TILE * NB_TILE * NB_TILEB);
  localparam int unsigned KA = $clog2(KK);

  logic          mac_valid;
  logic          mac_ready;
  logic [WA-1:0] w_addr;
  logic [AA-1:0] a_addr;
  logic [KA-1:0] k_idx;
  logic          acc_clr;
  logic          out_valid;
  logic          out_ready;
  logic [AA-1:0] out_tile;

  modport master (
    output mac_valid, w_addr, a_addr, k_idx, acc_clr, out_valid, out_tile,
    input  mac_ready, out_ready
  );

  modport slave (
    input  mac_valid, w_addr, a_addr, k_idx, acc_clr, out_valid, out_tile,
    output mac_ready, out_ready
  );
endinterface

// File: rtl/npu_tile_sched.sv
// Conv-layer tile scheduler: walks output-channel, spatial and input-channel tiles, issuing one
// MAC step per kernel tap with registered weight/activation addresses and an output drain handshake.
module npu_tile_sched #(
  parameter int unsigned W        = 8,
  parameter int unsigned K        = 5,
  parameter int unsigned NB_TILE  = 4,
  parameter int unsigned NB_TILEB = 6,
  parameter int unsigned NB_TILEC = 16,
  parameter int unsigned PIPE_LAT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       cfg_tile,
  input  logic [2:0]       cfg_tileb,
  input  logic [4:0]       cfg_tilec,
  npu_tile_sched_if.master dp,
  output logic             busy,
  output logic             done,
  output logic             cfg_err
);
  localparam int unsigned KK = K * K;
  localparam int unsigned WA = $clog2(KK * NB_TILEC);
  localparam int unsigned AA = $clog2(NB_TILE * NB_TILE * NB_TILEB);
  localparam int unsigned KA = $clog2(KK);
  // Degenerate settings fall back to a single WAIT cycle so out_valid is still registered.
  localparam int unsigned PipeLat = (PIPE_LAT == 0 || W == 0) ? 1 : PIPE_LAT;
  localparam int unsigned LW = $clog2(PipeLat + 1);

  typedef enum logic [2:0] {StIdle, StClr, StMac, StWait, StOut, StDone} state_e;

  state_e        state_q;
  logic [2:0]    cfg_tile_q, cfg_tileb_q;
  logic [4:0]    cfg_tilec_q;
  logic [KA-1:0] k_q;
  logic [2:0]    b_q, tx_q, ty_q;
  logic [4:0]    c_q;
  logic [LW-1:0] wait_q;
  logic [WA-1:0] w_addr_q;
  logic [AA-1:0] a_addr_q, out_tile_q;
  logic          mac_valid_q, acc_clr_q, out_valid_q, busy_q, done_q, cfg_err_q;

  logic          cfg_legal, tx_last, ty_last, c_last, last_tile;
  logic [2:0]    tx_n, ty_n;
  logic [4:0]    c_n;
  logic [WA-1:0] w_base_n;
  logic [AA-1:0] a_base_n, tile_idx;

  always_comb begin
    cfg_legal = (cfg_tile  != 3'd0) && (32'(cfg_tile)  <= NB_TILE)  &&
                (cfg_tileb != 3'd0) && (32'(cfg_tileb) <= NB_TILEB) &&
                (cfg_tilec != 5'd0) && (32'(cfg_tilec) <= NB_TILEC);
    tx_last   = (tx_q == cfg_tile_q - 3'd1);
    ty_last   = (ty_q == cfg_tile_q - 3'd1);
    c_last    = (c_q == cfg_tilec_q - 5'd1);
    last_tile = tx_last && ty_last && c_last;
    tx_n      = tx_last ? 3'd0 : tx_q + 3'd1;
    ty_n      = tx_last ? (ty_last ? 3'd0 : ty_q + 3'd1) : ty_q;
    c_n       = (tx_last && ty_last) ? c_q + 5'd1 : c_q;
    // Base addresses of the tile that follows the one being drained.
    w_base_n  = WA'(32'(c_n) * KK);
    a_base_n  = AA'((32'(ty_n) * 32'(cfg_tile_q) + 32'(tx_n)) * 32'(cfg_tileb_q));
    tile_idx  = AA'((32'(c_q) * 32'(cfg_tile_q) + 32'(ty_q)) * 32'(cfg_tile_q) + 32'(tx_q));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cfg_tile_q  <= '0;
      cfg_tileb_q <= '0;
      cfg_tilec_q <= '0;
      k_q         <= '0;
      b_q         <= '0;
      tx_q        <= '0;
      ty_q        <= '0;
      c_q         <= '0;
      wait_q      <= '0;
      w_addr_q    <= '0;
      a_addr_q    <= '0;
      out_tile_q  <= '0;
      mac_valid_q <= 1'b0;
      acc_clr_q   <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
    end else begin
      cfg_err_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (start) begin
            if (cfg_legal) begin
              cfg_tile_q  <= cfg_tile;
              cfg_tileb_q <= cfg_tileb;
              cfg_tilec_q <= cfg_tilec;
              k_q         <= '0;
              b_q         <= '0;
              tx_q        <= '0;
              ty_q        <= '0;
              c_q         <= '0;
              w_addr_q    <= '0;
              a_addr_q    <= '0;
              acc_clr_q   <= 1'b1;
              busy_q      <= 1'b1;
              state_q     <= StClr;
            end else begin
              cfg_err_q <= 1'b1;
            end
          end
        end
        StClr: begin
          acc_clr_q   <= 1'b0;
          mac_valid_q <= 1'b1;
          state_q     <= StMac;
        end
        StMac: begin
          if (dp.mac_ready) begin
            if (k_q == KA'(KK - 1)) begin
              if (b_q == cfg_tileb_q - 3'd1) begin
                // Addresses hold their last values through WAIT/OUT.
                b_q         <= '0;
                mac_valid_q <= 1'b0;
                wait_q      <= '0;
                state_q     <= StWait;
              end else begin
                k_q      <= '0;
                b_q      <= b_q + 3'd1;
                w_addr_q <= w_addr_q - WA'(KK - 1);
                a_addr_q <= a_addr_q + AA'(1);
              end
            end else begin
              k_q      <= k_q + KA'(1);
              w_addr_q <= w_addr_q + WA'(1);
            end
          end
        end
        StWait: begin
          if (wait_q == LW'(PipeLat - 1)) begin
            out_valid_q <= 1'b1;
            out_tile_q  <= tile_idx;
            state_q     <= StOut;
          end else begin
            wait_q <= wait_q + LW'(1);
          end
        end
        StOut: begin
          if (dp.out_ready) begin
            out_valid_q <= 1'b0;
            tx_q        <= tx_n;
            ty_q        <= ty_n;
            c_q         <= c_n;
            if (last_tile) begin
              done_q  <= 1'b1;
              state_q <= StDone;
            end else begin
              k_q       <= '0;
              b_q       <= '0;
              w_addr_q  <= w_base_n;
              a_addr_q  <= a_base_n;
              acc_clr_q <= 1'b1;
              state_q   <= StClr;
            end
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          tx_q    <= '0;
          ty_q    <= '0;
          c_q     <= '0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign dp.mac_valid = mac_valid_q;
  assign dp.w_addr    = w_addr_q;
  assign dp.a_addr    = a_addr_q;
  assign dp.k_idx     = k_q;
  assign dp.acc_clr   = acc_clr_q;
  assign dp.out_valid = out_valid_q;
  assign dp.out_tile  = out_tile_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign cfg_err      = cfg_err_q;
endmodule

// File: tb/tb_npu_tile_sched.sv
// Scoreboard bench for npu_tile_sched: a loop-nest model queues expected MAC steps and output
// tiles at start; a negedge monitor pops and compares them as the scheduler retires work.
module tb_npu_tile_sched;
  localparam int unsigned KK = 25;

  typedef struct packed {
    logic [8:0] w;
    logic [6:0] a;
    logic [4:0] k;
  } step_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start = 1'b0;
  logic [2:0] cfg_tile = '0;
  logic [2:0] cfg_tileb = '0;
  logic [4:0] cfg_tilec = '0;
  logic       busy, done, cfg_err;

  npu_tile_sched_if dp ();

  npu_tile_sched u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .cfg_tile  (cfg_tile),
    .cfg_tileb (cfg_tileb),
    .cfg_tilec (cfg_tilec),
    .dp        (dp),
    .busy      (busy),
    .done      (done),
    .cfg_err   (cfg_err)
  );

  always #5 clk = ~clk;

  step_t      mac_q[$];
  logic [6:0] out_q[$];
  int         n_vec = 0;
  int         n_fail = 0;
  int         n_clr = 0, n_steps = 0, n_out = 0, n_done = 0;
  logic [8:0] last_w = '0;
  step_t      mon_e;
  logic [6:0] mon_t;
  logic       p_mv = 1'b0, p_mr = 1'b0, p_ov = 1'b0, p_or = 1'b0;
  logic [8:0] p_w = '0;
  logic [6:0] p_a = '0, p_ot = '0;
  logic [4:0] p_k = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic gen_expect(input int tile, input int tileb, input int tilec);
    mac_q.delete();
    out_q.delete();
    for (int c = 0; c < tilec; c++)
      for (int ty = 0; ty < tile; ty++)
        for (int tx = 0; tx < tile; tx++) begin
          out_q.push_back(7'((c * tile + ty) * tile + tx));
          for (int b = 0; b < tileb; b++)
            for (int k = 0; k < int'(KK); k++)
              mac_q.push_back('{w: 9'(c * int'(KK) + k), a: 7'((ty * tile + tx) * tileb + b),
                                k: 5'(k)});
        end
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_mac_valid"}, 32'(dp.mac_valid), 0);
    check({tag, "_acc_clr"},   32'(dp.acc_clr), 0);
    check({tag, "_out_valid"}, 32'(dp.out_valid), 0);
    check({tag, "_busy"},      32'(busy), 0);
    check({tag, "_done"},      32'(done), 0);
    check({tag, "_cfg_err"},   32'(cfg_err), 0);
    check({tag, "_w_addr"},    32'(dp.w_addr), 0);
    check({tag, "_a_addr"},    32'(dp.a_addr), 0);
    check({tag, "_k_idx"},     32'(dp.k_idx), 0);
    check({tag, "_out_tile"},  32'(dp.out_tile), 0);
  endtask

  // Monitor: scoreboard pops, stall-hold and mutual-exclusion properties.
  always @(negedge clk) begin
    if (rst_n) begin
      if (dp.acc_clr) n_clr++;
      if (done) n_done++;
      if (dp.mac_valid || dp.out_valid)
        check("excl", 32'(dp.mac_valid & dp.out_valid), 0);
      if (p_mv && !p_mr) begin
        check("mac_hold_v", 32'(dp.mac_valid), 1);
        check("mac_hold_w", 32'(dp.w_addr), 32'(p_w));
        check("mac_hold_a", 32'(dp.a_addr), 32'(p_a));
        check("mac_hold_k", 32'(dp.k_idx), 32'(p_k));
      end
      if (p_ov && !p_or) begin
        check("out_hold_v", 32'(dp.out_valid), 1);
        check("out_hold_tile", 32'(dp.out_tile), 32'(p_ot));
      end
      if (dp.mac_valid && dp.mac_ready) begin
        n_steps++;
        last_w = dp.w_addr;
        check("mac_q_nonempty", 32'(mac_q.size() != 0), 1);
        if (mac_q.size() != 0) begin
          mon_e = mac_q.pop_front();
          check("w_addr", 32'(dp.w_addr), 32'(mon_e.w));
          check("a_addr", 32'(dp.a_addr), 32'(mon_e.a));
          check("k_idx",  32'(dp.k_idx),  32'(mon_e.k));
        end
      end
      if (dp.out_valid && dp.out_ready) begin
        n_out++;
        check("out_q_nonempty", 32'(out_q.size() != 0), 1);
        if (out_q.size() != 0) begin
          mon_t = out_q.pop_front();
          check("out_tile", 32'(dp.out_tile), 32'(mon_t));
        end
      end
    end
    p_mv = rst_n & dp.mac_valid;
    p_mr = dp.mac_ready;
    p_ov = rst_n & dp.out_valid;
    p_or = dp.out_ready;
    p_w  = dp.w_addr;
    p_a  = dp.a_addr;
    p_k  = dp.k_idx;
    p_ot = dp.out_tile;
  end

  task automatic run_layer(input int tile, input int tileb, input int tilec, input bit rnd,
                           input bit out_hold, input bit busy_start, input string tag);
    int tiles  = tilec * tile * tile;
    int steps  = tiles * tileb * int'(KK);
    int budget = steps * 4 + tiles * 40 + 200;
    int hold_cnt = 0;
    int cyc = 0;
    gen_expect(tile, tileb, tilec);
    n_clr = 0; n_steps = 0; n_out = 0; n_done = 0;
    @(posedge clk); #1;
    cfg_tile  = 3'(tile);
    cfg_tileb = 3'(tileb);
    cfg_tilec = 5'(tilec);
    dp.mac_ready = 1'b1;
    dp.out_ready = !out_hold;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_busy_hi"}, 32'(busy), 1);
    check({tag, "_acc_clr_first"}, 32'(dp.acc_clr), 1);
    while (n_done == 0 && cyc < budget) begin
      dp.mac_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_hold && hold_cnt < 10) begin
        dp.out_ready = 1'b0;
        if (dp.out_valid) hold_cnt++;
      end else begin
        dp.out_ready = 1'b1;
      end
      if (busy_start && cyc == 50) begin
        cfg_tile = 3'd1; cfg_tileb = 3'd1; cfg_tilec = 5'd1;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    dp.mac_ready = 1'b1;
    dp.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_done_count"}, 32'(n_done), 1);
    check({tag, "_acc_clr_count"}, 32'(n_clr), 32'(tiles));
    check({tag, "_step_count"}, 32'(n_steps), 32'(steps));
    check({tag, "_out_count"}, 32'(n_out), 32'(tiles));
    check({tag, "_mac_left"}, 32'(mac_q.size()), 0);
    check({tag, "_out_left"}, 32'(out_q.size()), 0);
    check({tag, "_busy_lo"}, 32'(busy), 0);
  endtask

  task automatic cfg_bad(input int tile, input int tileb, input int tilec, input string tag);
    @(posedge clk); #1;
    cfg_tile  = 3'(tile);
    cfg_tileb = 3'(tileb);
    cfg_tilec = 5'(tilec);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, "_pulse"}, 32'(cfg_err), 1);
    check({tag, "_busy"}, 32'(busy), 0);
    @(posedge clk); #1;
    check({tag, "_pulse_end"}, 32'(cfg_err), 0);
    check({tag, "_still_idle"}, 32'(busy), 0);
  endtask

  initial begin
    dp.mac_ready = 1'b1;
    dp.out_ready = 1'b1;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    check_idle_zero("rst");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    run_layer(4, 1, 6, 1'b0, 1'b0, 1'b0, "c1");
    run_layer(4, 1, 6, 1'b0, 1'b0, 1'b1, "c1_busy_start");
    run_layer(2, 6, 16, 1'b0, 1'b0, 1'b0, "c2");
    check("c2_last_w", 32'(last_w), 399);
    run_layer(4, 1, 6, 1'b1, 1'b1, 1'b0, "c1_stall");

    cfg_bad(4, 1, 0, "err_tilec0");
    cfg_bad(5, 1, 6, "err_tile5");

    // Abort a layer mid-MAC with reset, then run a fresh layer.
    gen_expect(4, 1, 6);
    @(posedge clk); #1;
    cfg_tile = 3'd4; cfg_tileb = 3'd1; cfg_tilec = 5'd6;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    check("midrst_busy_before", 32'(busy), 1);
    check("midrst_mac_before", 32'(dp.mac_valid), 1);
    rst_n = 1'b0;
    #1;
    check_idle_zero("midrst");
    mac_q.delete();
    out_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    run_layer(4, 1, 6, 1'b0, 1'b0, 1'b0, "c1_after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
